// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - mid-bit sample strobe and bit counter for a serial receiver
// Optional edge resynchronisation: define RX_BIT_TIMER_RESYNC_EN.
module rx_bit_timer #(
  parameter int CNT_BITS = 8,
  parameter int BIT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_bit,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] clks_per_bit,
  input  logic [BIT_BITS-1:0] bits_per_packet,
  input  logic                d_edge,
  output logic                shift_strobe,
  output logic [BIT_BITS-1:0] bit_index,
  output logic                packet_done,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] clk_cnt, clk_cnt_nxt;
  logic [CNT_BITS-1:0] cpb, cpb_nxt;
  logic [BIT_BITS-1:0] bit_cnt, bit_cnt_nxt;
  logic [BIT_BITS-1:0] bpp, bpp_nxt;
  logic                phase_last;
  logic                bit_last;

  assign phase_last = (clk_cnt == cpb - CNT_BITS'(1));
  assign bit_last   = (bit_cnt == bpp - BIT_BITS'(1));

`ifndef RX_BIT_TIMER_RESYNC_EN
  logic unused_d_edge;
  assign unused_d_edge = d_edge;
`endif

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    cpb_nxt     = cpb;
    bpp_nxt     = bpp;
    if (abort) begin
      state_nxt   = IDLE;
      clk_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_bit) begin
            // Clamp so the mid-bit point and the wrap compare never coincide at 0
            cpb_nxt     = (clks_per_bit < CNT_BITS'(2)) ? CNT_BITS'(2) : clks_per_bit;
            bpp_nxt     = (bits_per_packet == '0) ? BIT_BITS'(1) : bits_per_packet;
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            state_nxt   = RUN;
          end
        end
        RUN: begin
          if (phase_last) begin
            clk_cnt_nxt = '0;
            if (bit_last) state_nxt = DONE;
            else          bit_cnt_nxt = bit_cnt + BIT_BITS'(1);
`ifdef RX_BIT_TIMER_RESYNC_EN
          end else if (d_edge) begin
            clk_cnt_nxt = '0;
`endif
          end else begin
            clk_cnt_nxt = clk_cnt + CNT_BITS'(1);
          end
        end
        DONE: begin
          state_nxt   = IDLE;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
        default: begin
          state_nxt   = IDLE;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      cpb     <= '0;
      bpp     <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      cpb     <= cpb_nxt;
      bpp     <= bpp_nxt;
    end
  end

  assign shift_strobe = (state == RUN) && (clk_cnt == (cpb >> 1));
  assign packet_done  = (state == DONE);
  assign busy         = (state != IDLE);
  assign bit_index    = bit_cnt;

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb/tb_rx_bit_timer.sv - vector table, directed corners and random run against a timeline model
module tb_rx_bit_timer;

  logic       clk;
  logic       rst;
  logic       start_bit;
  logic       abort;
  logic [7:0] clks_per_bit;
  logic [3:0] bits_per_packet;
  logic       d_edge;
  logic       shift_strobe;
  logic [3:0] bit_index;
  logic       packet_done;
  logic       busy;

  rx_bit_timer #(.CNT_BITS(8), .BIT_BITS(4)) dut (
    .clk(clk), .rst(rst), .start_bit(start_bit), .abort(abort),
    .clks_per_bit(clks_per_bit), .bits_per_packet(bits_per_packet), .d_edge(d_edge),
    .shift_strobe(shift_strobe), .bit_index(bit_index),
    .packet_done(packet_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests, n_fail;
  // Model: a packet is a timeline starting at cycle m_t0; bit and phase follow by division
  int m_mode, m_t0, m_cpb, m_bpp, cyc;
  logic m_bi_known;
  int rc, busy_cnt;
  int sq[$];
  int dq[$];

  typedef struct {
    logic r, st, ab;
    int   cpb, bpp;
    logic e_strobe, e_busy, e_done, chk_bi;
    int   e_bi;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    int e, cv, bv;
    e  = cyc - m_t0;
    cv = int'(clks_per_bit);
    bv = int'(bits_per_packet);
    if (rst || abort) begin
      m_mode = 0;
      m_bi_known = 1'b1;
    end else if (m_mode == 0) begin
      if (start_bit) begin
        m_mode = 1;
        m_t0   = cyc + 1;
        m_cpb  = (cv < 2) ? 2 : cv;
        m_bpp  = (bv < 1) ? 1 : bv;
      end
    end else if (m_mode == 1) begin
      if (e == m_cpb * m_bpp - 1) m_mode = 2;
`ifdef RX_BIT_TIMER_RESYNC_EN
      else if (d_edge && (e % m_cpb) != m_cpb - 1) m_t0 = cyc + 1 - (e / m_cpb) * m_cpb;
`endif
    end else begin
      m_mode = 0;
      m_bi_known = 1'b0;
    end
    cyc++;
  endtask

  task automatic compare_model();
    int e;
    logic x_strobe, chk_bi;
    int x_bi;
    x_strobe = 1'b0;
    x_bi     = 0;
    chk_bi   = 1'b0;
    if (m_mode == 1) begin
      e        = cyc - m_t0;
      x_strobe = ((e % m_cpb) == m_cpb / 2);
      x_bi     = e / m_cpb;
      chk_bi   = 1'b1;
    end else if (m_mode == 0) begin
      chk_bi = m_bi_known;
    end
    chk("shift_strobe", int'(shift_strobe), int'(x_strobe));
    chk("busy", int'(busy), int'(m_mode != 0));
    chk("packet_done", int'(packet_done), int'(m_mode == 2));
    if (chk_bi) chk("bit_index", int'(bit_index), x_bi);
  endtask

  task automatic step(input logic r, input logic st, input logic ab, input logic de,
                      input int cpbv, input int bppv);
    rst = r; start_bit = st; abort = ab; d_edge = de;
    clks_per_bit = cpbv[7:0];
    bits_per_packet = bppv[3:0];
    @(posedge clk);
    model_update();
    rc++;
    #1;
    compare_model();
    if (shift_strobe) sq.push_back(rc);
    if (packet_done) dq.push_back(rc);
    if (busy) busy_cnt++;
  endtask

  task automatic plain(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 10, 9);
  endtask

  task automatic begin_pkt();
    sq.delete();
    dq.delete();
    rc = 0;
    busy_cnt = 0;
  endtask

  task automatic check_nominal(input string tag, input int base);
    chk({tag, "_n_strobes"}, sq.size(), 9);
    for (int i = 0; i < 9 && i < sq.size(); i++)
      chk({tag, "_strobe_cycle"}, sq[i], base + 5 + 10 * i);
    chk({tag, "_n_done"}, dq.size(), 1);
    if (dq.size() > 0) chk({tag, "_done_cycle"}, dq[0], base + 90);
  endtask

  task automatic abort_case(input logic use_rst);
    begin_pkt();
    step(1'b0, 1'b1, 1'b0, 1'b0, 10, 9);
    plain(39);
    step(use_rst, 1'b0, ~use_rst, 1'b0, 10, 9);
    chk(use_rst ? "rst_mid_busy" : "abort_mid_busy", int'(busy), 0);
    chk(use_rst ? "rst_mid_done" : "abort_mid_done", dq.size(), 0);
    plain(4);
    begin_pkt();
    rc = 45;
    step(1'b0, 1'b1, 1'b0, 1'b0, 10, 9);
    plain(95);
    check_nominal(use_rst ? "after_rst" : "after_abort", 46);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; rc = 0; busy_cnt = 0;
    m_mode = 0; m_t0 = 0; m_cpb = 2; m_bpp = 1; m_bi_known = 1'b0;
    rst = 1'b1; start_bit = 1'b0; abort = 1'b0; d_edge = 1'b0;
    clks_per_bit = 8'd0; bits_per_packet = 4'd0;

    //          r    st   ab   cpb bpp strobe busy done chkbi bi
    vecs[0]  = '{1'b1,1'b0,1'b0, 0, 0, 1'b0,1'b0,1'b0,1'b1, 0};
    vecs[1]  = '{1'b1,1'b1,1'b0, 5, 5, 1'b0,1'b0,1'b0,1'b1, 0};
    vecs[2]  = '{1'b0,1'b0,1'b0, 0, 0, 1'b0,1'b0,1'b0,1'b1, 0};
    vecs[3]  = '{1'b0,1'b1,1'b0, 1, 0, 1'b0,1'b1,1'b0,1'b1, 0};
    vecs[4]  = '{1'b0,1'b0,1'b0, 1, 0, 1'b1,1'b1,1'b0,1'b1, 0};
    vecs[5]  = '{1'b0,1'b0,1'b0, 1, 0, 1'b0,1'b1,1'b1,1'b0, 0};
    vecs[6]  = '{1'b0,1'b0,1'b0, 1, 0, 1'b0,1'b0,1'b0,1'b0, 0};
    vecs[7]  = '{1'b0,1'b1,1'b0, 3, 2, 1'b0,1'b1,1'b0,1'b1, 0};
    vecs[8]  = '{1'b0,1'b1,1'b0, 7, 7, 1'b1,1'b1,1'b0,1'b1, 0};
    vecs[9]  = '{1'b0,1'b0,1'b0, 3, 2, 1'b0,1'b1,1'b0,1'b1, 0};
    vecs[10] = '{1'b0,1'b0,1'b0, 3, 2, 1'b0,1'b1,1'b0,1'b1, 1};
    vecs[11] = '{1'b0,1'b0,1'b0, 3, 2, 1'b1,1'b1,1'b0,1'b1, 1};
    vecs[12] = '{1'b0,1'b1,1'b1, 3, 2, 1'b0,1'b0,1'b0,1'b1, 0};
    vecs[13] = '{1'b0,1'b1,1'b0, 2, 1, 1'b0,1'b1,1'b0,1'b1, 0};
    vecs[14] = '{1'b0,1'b0,1'b0, 2, 1, 1'b1,1'b1,1'b0,1'b1, 0};
    vecs[15] = '{1'b0,1'b0,1'b0, 2, 1, 1'b0,1'b1,1'b1,1'b0, 0};
    vecs[16] = '{1'b0,1'b1,1'b0, 2, 1, 1'b0,1'b0,1'b0,1'b0, 0};
    vecs[17] = '{1'b0,1'b0,1'b0, 2, 1, 1'b0,1'b0,1'b0,1'b0, 0};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].st, vecs[i].ab, 1'b0, vecs[i].cpb, vecs[i].bpp);
      chk($sformatf("vec%0d_strobe", i), int'(shift_strobe), int'(vecs[i].e_strobe));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(packet_done), int'(vecs[i].e_done));
      if (vecs[i].chk_bi) chk($sformatf("vec%0d_bit_index", i), int'(bit_index), vecs[i].e_bi);
    end

    // Reset then idle
    step(1'b1, 1'b0, 1'b0, 1'b0, 10, 9);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10, 9);
    begin_pkt();
    plain(20);
    chk("idle_busy_cycles", busy_cnt, 0);
    chk("idle_strobes", sq.size(), 0);

    // Nominal packet
    begin_pkt();
    step(1'b0, 1'b1, 1'b0, 1'b0, 10, 9);
    plain(95);
    check_nominal("nominal", 1);
    chk("nominal_busy_cycles", busy_cnt, 91);

    abort_case(1'b0);
    abort_case(1'b1);

    // Repeated start pulses (including one during DONE) and a changed clks_per_bit
    begin_pkt();
    step(1'b0, 1'b1, 1'b0, 1'b0, 10, 9);
    while (rc < 100) step(1'b0, (rc % 7 == 0) && (rc <= 91), 1'b0, 1'b0, 4, 3);
    check_nominal("ignored", 1);
    chk("ignored_busy_cycles", busy_cnt, 91);

    // Edge resynchronisation
    begin_pkt();
    step(1'b0, 1'b1, 1'b0, 1'b0, 10, 9);
    plain(12);
    step(1'b0, 1'b0, 1'b0, 1'b1, 10, 9);
    chk("resync_bit_index", int'(bit_index), 1);
    plain(6);
    chk("resync_n_strobes", sq.size(), 2);
`ifdef RX_BIT_TIMER_RESYNC_EN
    if (sq.size() > 1) chk("resync_strobe_cycle", sq[1], 19);
`else
    if (sq.size() > 1) chk("resync_strobe_cycle", sq[1], 16);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0, 10, 9);

    // Widest bit period: counter must reach 254 without overflow
    begin_pkt();
    step(1'b0, 1'b1, 1'b0, 1'b0, 255, 2);
    plain(515);
    chk("wide_n_strobes", sq.size(), 2);
    if (sq.size() > 1) begin
      chk("wide_strobe0", sq[0], 128);
      chk("wide_strobe1", sq[1], 383);
    end
    chk("wide_n_done", dq.size(), 1);
    if (dq.size() > 0) chk("wide_done_cycle", dq[0], 511);

    // Random traffic against the model
    repeat (3000) begin
      step(($urandom % 400) == 0, ($urandom % 12) == 0, ($urandom % 150) == 0,
           ($urandom % 9) == 0, int'($urandom_range(0, 12)), int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Serial-receive timing controller that runs in parallel with the receive shift register.
- After a start-bit detect, it generates one mid-bit sample/shift strobe per bit period and counts bits to the end of the packet.
- Contains an internal clock-phase counter that wraps to 0 with a registered rollover, plus a bit counter.
- Outputs drive the shift-register enable and the packet-complete logic.

Parameters:
- CNT_BITS, 8, width of the clock-phase counter and of clks_per_bit
- BIT_BITS, 4, width of the bit counter, bits_per_packet and bit_index

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- start_bit  input  1  one-cycle pulse from the start-bit detector
- abort  input  1  force return to IDLE; no packet_done
- clks_per_bit  input  CNT_BITS  clock cycles per bit period; latched on accepted start
- bits_per_packet  input  BIT_BITS  bits per packet; latched on accepted start
- d_edge  input  1  data-line transition pulse; used only with the optional feature
- shift_strobe  output  1  one-cycle pulse at the bit-centre sample point
- bit_index  output  BIT_BITS  index of the bit currently being timed, 0-based
- packet_done  output  1  one-cycle pulse after the last bit period ends
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. While rst=1 at a clock edge:
  - state goes to IDLE;
  - clk_cnt=0, bit_cnt=0, latched copies=0;
  - all outputs read 0 from the next cycle onward.
  - Reset mid-packet aborts silently.
- States: IDLE, RUN, DONE, held in a registered state variable.
- IDLE:
  - start_bit=1 and abort=0: latch cpb=max(clks_per_bit,2) and bpp=max(bits_per_packet,1); clear clk_cnt and bit_cnt; go to RUN.
  - Otherwise remain in IDLE.
- RUN, each cycle:
  - If clk_cnt == cpb-1: clk_cnt wraps to 0 and bit_cnt increments; if bit_cnt == bpp-1 at that moment, go to DONE instead.
  - Otherwise clk_cnt increments by 1.
- DONE: lasts exactly one cycle, then goes to IDLE. A start_bit during DONE is ignored.
- Outputs, all combinational decodes of registered state only (no input-to-output paths):
  - shift_strobe = (state==RUN) && (clk_cnt == cpb>>1).
  - packet_done = (state==DONE).
  - busy = (state!=IDLE).
  - bit_index = bit_cnt.
- Timing example: start_bit sampled at edge E0, cpb=10, bpp=9.
  - RUN from cycle 1; strobes in cycles 6, 16, ..., 86 (9 total).
  - packet_done in cycle 91; IDLE from cycle 92.
- Boundary rules:
  - start_bit while busy is ignored; the latched cpb/bpp are unaffected.
  - abort in any state forces IDLE next cycle and clears counters; abort beats start_bit in the same cycle.
  - Changes to clks_per_bit or bits_per_packet during RUN have no effect.
  - cpb=2: strobe when clk_cnt=1.
  - Counter arithmetic is unsigned and wraps only via the compare, never via overflow. cpb up to 2^CNT_BITS-1 is supported.

Optional Feature:
- Macro: RX_BIT_TIMER_RESYNC_EN.
- Defined: in RUN, d_edge=1 with clk_cnt != cpb-1 reloads clk_cnt to 0 next cycle and leaves bit_cnt unchanged (edge resynchronisation). At clk_cnt == cpb-1 the normal wrap takes priority. abort and rst still take priority over resync.
- Not defined: d_edge is ignored entirely; behaviour is as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no start -> busy, shift_strobe, packet_done, bit_index all 0 indefinitely.
- Nominal packet: cpb=10, bpp=9, start pulse at E0 -> 9 strobes in cycles 6..86 step 10; bit_index 0..8; packet_done single cycle at 91; busy 1..91.
- Minimum values: clks_per_bit=1, bits_per_packet=0 -> treated as cpb=2, bpp=1; strobe in cycle 2, packet_done in cycle 3.
- Abort and reset mid-packet: abort in cycle 40 of nominal case -> IDLE in 41, no packet_done. Repeat with rst in cycle 40 -> same result. A new start at cycle 45 -> a full packet follows.
- Ignored inputs: start_bit every 7 cycles plus clks_per_bit changed to 4 during RUN -> timing identical to the nominal case.
- With RX_BIT_TIMER_RESYNC_EN: d_edge at cycle 13 (clk_cnt=2) -> clk_cnt=0 in cycle 14; next strobe in cycle 19, not 16; bit_index unchanged. Same stimulus without the macro -> strobe at 16.
